jtframe_prog_banker: RTL and testbench
======================================

// Module: jtframe_prog_banker
// PURPOSE
//  Parametrised successor to the fixed single-bank download path in the MiST/DeMiSTify top level.
//  Turns the ioctl byte stream into 16-bit SDRAM programming writes across 1-4 banks.
//  Buffers bytes in a small FIFO and drives the prog_* handshake toward the SDRAM controller.
//  Sits between the ioctl download port and jtframe_sdram prog interface.
// PARAMETERS
//  SDRAMW      22        word-address width per bank (22=32MB, 23=64MB total)
//  BANKS       4         banks in use, 1..4; banks >= BANKS never selected
//  BA1_START   25'h100000  first ioctl byte address mapped to bank 1
//  BA2_START   25'h200000  first ioctl byte address mapped to bank 2
//  BA3_START   25'h300000  first ioctl byte address mapped to bank 3
//  SWAB        0         1: even byte goes to upper byte lane
//  FIFO_DEPTH  4         entries, power of two, 2..16
// PORTS
//  clk          in   1         system clock (clk_rom domain)
//  rst_n        in   1         asynchronous active-low reset
//  downloading  in   1         ioctl download window active
//  ioctl_addr   in   25        byte address of ioctl_dout
//  ioctl_dout   in   8         download byte
//  ioctl_wr     in   1         one-cycle strobe, byte valid
//  prog_addr    out  SDRAMW    word address within selected bank
//  prog_data    out  16        {2{byte}}
//  prog_mask    out  2         active-low byte enables, bit0 = low byte
//  prog_ba      out  2         bank select
//  prog_we      out  1         write request, held until prog_ack
//  prog_ack     in   1         controller accepted request
//  prog_rdy     in   1         write completed
//  dwnld_busy   out  1         download or drain in progress
//  overflow     out  1         sticky: a byte was dropped on full FIFO
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, FSM=IDLE, all outputs 0 except prog_mask=2'b11.
//  Bank decode at push time: ba = highest i < BANKS with ioctl_addr >= BAi_START (BA0_START = 0).
//    offset = ioctl_addr - BAi_START.
//    Entry stored = {ba, offset[SDRAMW:1], offset[0], byte}.
//    offset bits above SDRAMW are discarded (wrap within bank).
//  Lane: mask = (offset[0] ^ SWAB) ? 2'b01 : 2'b10; data = {byte, byte} always.
//  Push: ioctl_wr && downloading.
//    Accepted when FIFO not full, or full with a pop in the same cycle.
//    Otherwise the byte is dropped and overflow is set.
//    ioctl_wr while !downloading is ignored.
//  Overflow clears only on reset or on the rising edge of downloading.
//  FSM:
//    IDLE  -> ISSUE when FIFO non-empty.
//             Pop head; register prog_addr/ba/mask/data; prog_we=1.
//    ISSUE -> WAIT on prog_ack.
//             prog_we drops the cycle after ack; address/ba/mask/data stay stable until WAIT exits.
//    WAIT  -> IDLE on prog_rdy.
//             prog_mask returns to 2'b11.
//             If prog_rdy and prog_ack arrive together in ISSUE, go directly to IDLE.
//  Latency: ioctl_wr at cycle n into an empty FIFO with FSM in IDLE gives prog_we=1 at cycle n+2.
//  Throughput: one write per ack/rdy round trip; no request pipelining.
//  dwnld_busy = downloading | FIFO non-empty | FSM != IDLE, registered (one-cycle lag).
//  When downloading falls, queued bytes still drain; dwnld_busy falls the cycle after the last prog_rdy.
//  Reset mid-transfer aborts immediately: prog_we=0, FIFO flushed; no partial-state recovery.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits: full when MSBs differ and the rest are equal.
// TESTING
//  1. BANKS=4, defaults; bytes 0xA5 @0x000000, 0x5A @0x000001, rdy 3 cycles after ack.
//     -> ba=0, addr=0, mask=2'b10 data=16'hA5A5, then mask=2'b01 data=16'h5A5A.
//  2. Byte 0x11 @0x200003 -> ba=2, prog_addr=1, mask=2'b01.
//     Same stimulus with BANKS=2 -> ba=1, prog_addr=0x80001.
//  3. Hold prog_ack low, push 6 bytes with FIFO_DEPTH=4.
//     -> exactly 4 bytes queued plus 1 in flight accepted; 6th dropped; overflow=1 until next download start.
//  4. downloading falls with 3 bytes queued.
//     -> 3 further writes issued; dwnld_busy falls one cycle after the final prog_rdy.
//  5. rst_n pulse low while prog_we=1.
//     -> prog_we=0, prog_mask=2'b11, FIFO empty, dwnld_busy=0 asynchronously.
//  6. SWAB=1, byte @even address -> mask=2'b01.
//     prog_ack+prog_rdy in the same cycle -> FSM returns to IDLE, next entry issued on the following cycle.

Source files
------------

// File: rtl/jtframe_prog_banker_if.sv
// Bus bundle between the ioctl download port, the banker and the SDRAM prog port.
// master is the banker's view; slave is the view of the surrounding ioctl/SDRAM side.
interface jtframe_prog_banker_if #(
  parameter int SDRAMW = 22
);
  logic              downloading;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic [SDRAMW-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic [1:0]        prog_ba;
  logic              prog_we;
  logic              prog_ack;
  logic              prog_rdy;
  logic              dwnld_busy;
  logic              overflow;

  modport master (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_ack, prog_rdy,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
  );

  modport slave (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, prog_ack, prog_rdy,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, dwnld_busy, overflow
  );
endinterface

// File: rtl/jtframe_prog_banker.sv
// Converts the ioctl download byte stream into banked 16-bit SDRAM programming writes.
// Bytes are bank-decoded on entry, queued in a small FIFO and issued one at a time.
//
// state    | meaning
// ST_IDLE  | no request outstanding; pops the FIFO head when one is available
// ST_ISSUE | prog_we high, waiting for prog_ack
// ST_WAIT  | request accepted, waiting for prog_rdy
module jtframe_prog_banker #(
  parameter int          SDRAMW     = 22,
  parameter int          BANKS      = 4,
  parameter logic [24:0] BA1_START  = 25'h100000,
  parameter logic [24:0] BA2_START  = 25'h200000,
  parameter logic [24:0] BA3_START  = 25'h300000,
  parameter int          SWAB       = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtframe_prog_banker_if.master bus
);
  localparam int   AW       = $clog2(FIFO_DEPTH);
  localparam int   PW       = AW + 1;
  localparam int   EW       = 2 + SDRAMW + 1 + 8;
  localparam logic SWAB_BIT = (SWAB != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     wp, rp;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic              empty, full, push_req, push, pop, drop;
  logic [1:0]        ba_sel;
  logic [SDRAMW:0]   base_sel, offset;
  logic [EW-1:0]     new_entry, head;
  logic [1:0]        head_ba;
  logic [SDRAMW-1:0] head_addr;
  logic              head_lsb;
  logic [7:0]        head_byte;

  logic [SDRAMW-1:0] addr_q, addr_nxt;
  logic [15:0]       data_q, data_nxt;
  logic [1:0]        mask_q, mask_nxt;
  logic [1:0]        ba_q, ba_nxt;
  logic              we_q, we_nxt;
  logic              busy_q, ovf_q, dl_q;

  assign empty    = (wp == rp);
  assign full     = (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push_req = bus.ioctl_wr & bus.downloading;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & ~push;

  // Later matches override earlier ones, so the highest qualifying bank wins.
  always_comb begin
    ba_sel   = 2'd0;
    base_sel = '0;
    if (BANKS > 1 && bus.ioctl_addr >= BA1_START) begin
      ba_sel   = 2'd1;
      base_sel = BA1_START[SDRAMW:0];
    end
    if (BANKS > 2 && bus.ioctl_addr >= BA2_START) begin
      ba_sel   = 2'd2;
      base_sel = BA2_START[SDRAMW:0];
    end
    if (BANKS > 3 && bus.ioctl_addr >= BA3_START) begin
      ba_sel   = 2'd3;
      base_sel = BA3_START[SDRAMW:0];
    end
  end

  // Only the low SDRAMW+1 offset bits are kept, so the subtraction is done at that width.
  assign offset    = bus.ioctl_addr[SDRAMW:0] - base_sel;
  assign new_entry = {ba_sel, offset, bus.ioctl_dout};

  assign head      = mem[rp[AW-1:0]];
  assign head_ba   = head[EW-1 -: 2];
  assign head_addr = head[9 +: SDRAMW];
  assign head_lsb  = head[8];
  assign head_byte = head[7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    mask_nxt  = mask_q;
    ba_nxt    = ba_q;
    we_nxt    = we_q;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          addr_nxt  = head_addr;
          ba_nxt    = head_ba;
          data_nxt  = {2{head_byte}};
          mask_nxt  = (head_lsb ^ SWAB_BIT) ? 2'b01 : 2'b10;
          we_nxt    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.prog_ack) begin
          we_nxt = 1'b0;
          if (bus.prog_rdy) begin
            mask_nxt  = 2'b11;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.prog_rdy) begin
          mask_nxt  = 2'b11;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= 2'b11;
      ba_q   <= '0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      mask_q <= mask_nxt;
      ba_q   <= ba_nxt;
      we_q   <= we_nxt;
    end
  end

  // Overflow survives the end of a download so software can inspect it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      dl_q   <= 1'b0;
    end else begin
      busy_q <= bus.downloading | ~empty | (state != ST_IDLE);
      dl_q   <= bus.downloading;
      if (drop)                           ovf_q <= 1'b1;
      else if (bus.downloading && !dl_q)  ovf_q <= 1'b0;
    end
  end

  assign bus.prog_addr  = addr_q;
  assign bus.prog_data  = data_q;
  assign bus.prog_mask  = mask_q;
  assign bus.prog_ba    = ba_q;
  assign bus.prog_we    = we_q;
  assign bus.dwnld_busy = busy_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_jtframe_prog_banker.sv
// Directed bench for jtframe_prog_banker: a default instance and a BANKS=2, SWAB=1 instance.
module tb_jtframe_prog_banker;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jtframe_prog_banker_if #(.SDRAMW(22)) ia ();
  jtframe_prog_banker_if #(.SDRAMW(22)) ib ();

  jtframe_prog_banker #(.SDRAMW(22), .BANKS(4), .SWAB(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  jtframe_prog_banker #(.SDRAMW(22), .BANKS(2), .SWAB(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [24:0] addr, input logic [7:0] data);
    ia.ioctl_addr = addr;
    ia.ioctl_dout = data;
    ia.ioctl_wr   = 1'b1;
    tick();
    ia.ioctl_wr   = 1'b0;
  endtask

  // ack for one cycle, then rdy gap cycles after the ack
  task automatic handshake_a(input int gap);
    ia.prog_ack = 1'b1;
    tick();
    ia.prog_ack = 1'b0;
    chk("we_drop_after_ack", ia.prog_we, 1'b0);
    repeat (gap - 1) tick();
    ia.prog_rdy = 1'b1;
    tick();
    ia.prog_rdy = 1'b0;
    chk("mask_idle_after_rdy", ia.prog_mask, 2'b11);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ia.downloading = 0; ia.ioctl_addr = '0; ia.ioctl_dout = '0; ia.ioctl_wr = 0;
    ia.prog_ack = 0; ia.prog_rdy = 0;
    ib.downloading = 0; ib.ioctl_addr = '0; ib.ioctl_dout = '0; ib.ioctl_wr = 0;
    ib.prog_ack = 0; ib.prog_rdy = 0;
    tick();
    chk("rst_we", ia.prog_we, 1'b0);
    chk("rst_mask", ia.prog_mask, 2'b11);
    chk("rst_busy", ia.dwnld_busy, 1'b0);
    chk("rst_ovf", ia.overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Two bytes into bank 0, first one checks the two-cycle latency
    ia.downloading = 1'b1;
    ib.downloading = 1'b1;
    push_a(25'h000000, 8'hA5);
    chk("latency_n1_we", ia.prog_we, 1'b0);
    push_a(25'h000001, 8'h5A);
    chk("t1_we", ia.prog_we, 1'b1);
    chk("t1_ba", ia.prog_ba, 2'd0);
    chk("t1_addr", ia.prog_addr, 32'h0);
    chk("t1_mask", ia.prog_mask, 2'b10);
    chk("t1_data", ia.prog_data, 16'hA5A5);
    chk("busy_during_dl", ia.dwnld_busy, 1'b1);
    handshake_a(3);
    tick();
    chk("t1b_we", ia.prog_we, 1'b1);
    chk("t1b_mask", ia.prog_mask, 2'b01);
    chk("t1b_data", ia.prog_data, 16'h5A5A);
    chk("t1b_addr", ia.prog_addr, 32'h0);
    handshake_a(3);

    // Same byte into both instances: bank 2 on A, bank 1 on B (BANKS=2)
    ia.ioctl_addr = 25'h200003; ia.ioctl_dout = 8'h11; ia.ioctl_wr = 1'b1;
    ib.ioctl_addr = 25'h200003; ib.ioctl_dout = 8'h11; ib.ioctl_wr = 1'b1;
    tick();
    ia.ioctl_wr = 1'b0;
    ib.ioctl_wr = 1'b0;
    tick();
    chk("t2a_ba", ia.prog_ba, 2'd2);
    chk("t2a_addr", ia.prog_addr, 32'h1);
    chk("t2a_mask", ia.prog_mask, 2'b01);
    chk("t2a_data", ia.prog_data, 16'h1111);
    chk("t2b_ba", ib.prog_ba, 2'd1);
    chk("t2b_addr", ib.prog_addr, 32'h80001);
    chk("t2b_mask_swab_odd", ib.prog_mask, 2'b10);
    ib.prog_ack = 1'b1; ib.prog_rdy = 1'b1;
    tick();
    ib.prog_ack = 1'b0; ib.prog_rdy = 1'b0;
    handshake_a(2);

    // SWAB on B plus ack and rdy arriving together
    ib.ioctl_addr = 25'h000004; ib.ioctl_dout = 8'h33; ib.ioctl_wr = 1'b1;
    tick();
    ib.ioctl_addr = 25'h000005; ib.ioctl_dout = 8'h44;
    tick();
    ib.ioctl_wr = 1'b0;
    chk("t6_we", ib.prog_we, 1'b1);
    chk("t6_mask_swab_even", ib.prog_mask, 2'b01);
    chk("t6_addr", ib.prog_addr, 32'h2);
    chk("t6_data", ib.prog_data, 16'h3333);
    ib.prog_ack = 1'b1; ib.prog_rdy = 1'b1;
    tick();
    ib.prog_ack = 1'b0; ib.prog_rdy = 1'b0;
    chk("t6_ackrdy_we", ib.prog_we, 1'b0);
    chk("t6_ackrdy_mask", ib.prog_mask, 2'b11);
    tick();
    chk("t6_next_we", ib.prog_we, 1'b1);
    chk("t6_next_mask", ib.prog_mask, 2'b10);
    chk("t6_next_data", ib.prog_data, 16'h4444);
    ib.prog_ack = 1'b1; ib.prog_rdy = 1'b1;
    tick();
    ib.prog_ack = 1'b0; ib.prog_rdy = 1'b0;
    ib.downloading = 1'b0;

    // Overflow: six bytes with ack held low, 1 in flight + 4 queued, 6th dropped
    chk("ovf_before", ia.overflow, 1'b0);
    for (int i = 0; i < 6; i++) push_a(25'h10 + i, 8'h60 + i[7:0]);
    chk("ovf_set", ia.overflow, 1'b1);
    chk("ovf_inflight_addr", ia.prog_addr, 32'h8);
    ia.downloading = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drain_we", ia.prog_we, 1'b1);
      chk("drain_data", ia.prog_data, {2{8'h60 + i[7:0]}});
      chk("drain_mask", ia.prog_mask, i[0] ? 2'b01 : 2'b10);
      handshake_a(1);
      if (i != 4) tick();
    end
    chk("drain_busy_at_last_rdy", ia.dwnld_busy, 1'b1);
    tick();
    chk("drain_busy_fall", ia.dwnld_busy, 1'b0);
    chk("drain_no_extra_we", ia.prog_we, 1'b0);
    chk("ovf_sticky", ia.overflow, 1'b1);
    ia.downloading = 1'b1;
    tick();
    chk("ovf_clear_on_dl_rise", ia.overflow, 1'b0);

    // Reset in the middle of an outstanding request with bytes queued
    push_a(25'h40, 8'h77);
    push_a(25'h41, 8'h78);
    push_a(25'h42, 8'h79);
    chk("t5_we_before", ia.prog_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_we", ia.prog_we, 1'b0);
    chk("t5_async_mask", ia.prog_mask, 2'b11);
    chk("t5_async_busy", ia.dwnld_busy, 1'b0);
    ia.downloading = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_flushed_we", ia.prog_we, 1'b0);
    chk("t5_flushed_busy", ia.dwnld_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
